// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
// EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid
// buffer (main + skid). in_ready is a registered signal, so back-pressure from
// MEM never forms a combinational path into EX. The design sustains one
// transfer per cycle while unstalled.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   flush          discard held and incoming entries
//   in_valid       EX presents an instruction
//   in_ready       register can accept (registered)
//   alu_result_in  ALU result / memory address
//   rs2_data_in    store data
//   rd_in          destination register index
//   ctrl_in        control vector {mem_to_reg, mem_write, mem_read, reg_write}
//   out_valid      main entry holds a valid instruction
//   out_ready      MEM accepts this cycle
//   alu_result_out main entry ALU result
//   rs2_data_out   main entry store data
//   rd_out         main entry destination
//   ctrl_out       main entry control, zero when out_valid=0
//   occupancy      number of valid entries (0..2)
//   stall_cnt      saturating count of cycles with out_valid & ~out_ready
module ex_mem_skid_reg #(
  parameter int DATA_W      = 16,
  parameter int RD_W        = 4,
  parameter int CTRL_W      = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      alu_result_in,
  input  logic [DATA_W-1:0]      rs2_data_in,
  input  logic [RD_W-1:0]        rd_in,
  input  logic [CTRL_W-1:0]      ctrl_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      alu_result_out,
  output logic [DATA_W-1:0]      rs2_data_out,
  output logic [RD_W-1:0]        rd_out,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PAY_W = 2*DATA_W + RD_W + CTRL_W;

  logic [PAY_W-1:0] main_pay, skid_pay, in_pay;
  logic [PAY_W-1:0] main_pay_nxt, skid_pay_nxt;
  logic             main_valid, skid_valid;
  logic             main_valid_nxt, skid_valid_nxt;
  logic             in_ready_r;
  logic             in_fire, out_fire;
  logic [CTRL_W-1:0] ctrl_main;

  assign in_pay   = {alu_result_in, rs2_data_in, rd_in, ctrl_in};
  assign in_fire  = in_valid & in_ready_r;
  assign out_fire = main_valid & out_ready;

  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    main_pay_nxt   = main_pay;
    skid_pay_nxt   = skid_pay;
    if (flush) begin
      // payload left stale; ctrl_out is masked by out_valid
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_valid_nxt = 1'b1;
        main_pay_nxt   = in_pay;
      end
    end else if (out_fire) begin
      if (skid_valid) begin
        // in_ready was low, so no in_fire can coincide with draining skid
        main_pay_nxt   = skid_pay;
        skid_valid_nxt = 1'b0;
      end else if (in_fire) begin
        main_pay_nxt   = in_pay;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_nxt = 1'b1;
      skid_pay_nxt   = in_pay;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pay   <= '0;
      skid_pay   <= '0;
      in_ready_r <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      main_pay   <= main_pay_nxt;
      skid_pay   <= skid_pay_nxt;
      in_ready_r <= ~skid_valid_nxt;
      if (main_valid && !out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid;
  assign {alu_result_out, rs2_data_out, rd_out, ctrl_main} = main_pay;
  assign ctrl_out  = ctrl_main & {CTRL_W{main_valid}};
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] alu_result_in, rs2_data_in, alu_result_out, rs2_data_out;
  logic [3:0]  rd_in, ctrl_in, rd_out, ctrl_out;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.DATA_W(16), .RD_W(4), .CTRL_W(4), .STALL_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
    .rd_in(rd_in), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_out(alu_result_out), .rs2_data_out(rs2_data_out),
    .rd_out(rd_out), .ctrl_out(ctrl_out),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [15:0] alu;
    logic [3:0]  rd, ctrl;
    logic        e_ov, e_ir;
    logic [1:0]  e_occ;
    logic [15:0] e_alu;
    logic [3:0]  e_rd, e_ctrl, e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, f, iv, ordy, input logic [15:0] alu,
                     input logic [3:0] rd, ctrl, input logic e_ov, e_ir,
                     input logic [1:0] e_occ, input logic [15:0] e_alu,
                     input logic [3:0] e_rd, e_ctrl, e_stall);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy;
    v.alu = alu; v.rd = rd; v.ctrl = ctrl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ;
    v.e_alu = e_alu; v.e_rd = e_rd; v.e_ctrl = e_ctrl; v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // store data is always driven as the bitwise inverse of the ALU result
  task automatic drive(input logic r, f, iv, ordy, input logic [15:0] alu,
                       input logic [3:0] rd, ctrl);
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    alu_result_in = alu; rs2_data_in = ~alu; rd_in = rd; ctrl_in = ctrl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic e_ov, e_ir,
                           input logic [1:0] e_occ, input logic [3:0] e_ctrl,
                           input logic [3:0] e_stall);
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
    chk({tag, " in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
    chk({tag, " occupancy"}, {30'd0, occupancy}, {30'd0, e_occ});
    chk({tag, " ctrl_out"},  {28'd0, ctrl_out},  {28'd0, e_ctrl});
    chk({tag, " stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e_stall});
  endtask

  task automatic chk_data(input string tag, input logic [15:0] e_alu,
                          input logic [3:0] e_rd);
    chk({tag, " alu"}, {16'd0, alu_result_out}, {16'd0, e_alu});
    chk({tag, " rs2"}, {16'd0, rs2_data_out},   {16'd0, ~e_alu});
    chk({tag, " rd"},  {28'd0, rd_out},         {28'd0, e_rd});
  endtask

  initial begin
    logic [3:0] exp_stall;
    string      tag;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_result_in = '0; rs2_data_in = '0; rd_in = '0; ctrl_in = '0;

    //   rst f iv ordy alu       rd    ctrl    ov ir occ e_alu     e_rd  e_ctrl  stall
    // reset with junk input
    add(1, 0, 1, 0, 16'hAAAA, 4'hC, 4'hF,   0, 1, 0, 16'h0000, 4'h0, 4'h0,  4'd0);
    add(1, 0, 1, 0, 16'h5555, 4'h3, 4'hF,   0, 1, 0, 16'h0000, 4'h0, 4'h0,  4'd0);
    // streaming
    add(0, 0, 1, 1, 16'h1234, 4'h3, 4'h1,   1, 1, 1, 16'h1234, 4'h3, 4'h1,  4'd0);
    add(0, 0, 1, 1, 16'h5678, 4'h7, 4'h3,   1, 1, 1, 16'h5678, 4'h7, 4'h3,  4'd0);
    add(0, 0, 0, 1, 16'h0000, 4'h0, 4'h0,   0, 1, 0, 16'h0000, 4'h0, 4'h0,  4'd0);
    // back-pressure: A, B fill both entries, C refused until room
    add(0, 0, 1, 0, 16'h0001, 4'h1, 4'h5,   1, 1, 1, 16'h0001, 4'h1, 4'h5,  4'd0);
    add(0, 0, 1, 0, 16'h0002, 4'h2, 4'h2,   1, 0, 2, 16'h0001, 4'h1, 4'h5,  4'd1);
    add(0, 0, 1, 0, 16'h0003, 4'h3, 4'h8,   1, 0, 2, 16'h0001, 4'h1, 4'h5,  4'd2);
    add(0, 0, 1, 0, 16'h0003, 4'h3, 4'h8,   1, 0, 2, 16'h0001, 4'h1, 4'h5,  4'd3);
    add(0, 0, 1, 1, 16'h0003, 4'h3, 4'h8,   1, 1, 1, 16'h0002, 4'h2, 4'h2,  4'd3);
    add(0, 0, 1, 1, 16'h0003, 4'h3, 4'h8,   1, 1, 1, 16'h0003, 4'h3, 4'h8,  4'd3);
    add(0, 0, 0, 1, 16'h0000, 4'h0, 4'h0,   0, 1, 0, 16'h0000, 4'h0, 4'h0,  4'd3);
    // flush with both entries held and D incoming
    add(0, 0, 1, 0, 16'h0E0E, 4'h5, 4'h1,   1, 1, 1, 16'h0E0E, 4'h5, 4'h1,  4'd3);
    add(0, 0, 1, 0, 16'h0F0F, 4'h6, 4'h4,   1, 0, 2, 16'h0E0E, 4'h5, 4'h1,  4'd4);
    add(0, 1, 1, 0, 16'hDEAD, 4'h9, 4'hF,   0, 1, 0, 16'h0000, 4'h0, 4'h0,  4'd5);
    add(0, 0, 0, 1, 16'h0000, 4'h0, 4'h0,   0, 1, 0, 16'h0000, 4'h0, 4'h0,  4'd5);
    add(0, 0, 0, 0, 16'h0000, 4'h0, 4'h0,   0, 1, 0, 16'h0000, 4'h0, 4'h0,  4'd5);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].ordy,
            vecs[i].alu, vecs[i].rd, vecs[i].ctrl);
      tag = $sformatf("vec%0d", i);
      chk_state(tag, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_occ,
                vecs[i].e_ctrl, vecs[i].e_stall);
      if (vecs[i].e_ov) chk_data(tag, vecs[i].e_alu, vecs[i].e_rd);
    end

    // saturation: load G, then hold back-pressure for 20 cycles
    drive(0, 0, 1, 0, 16'h0A0A, 4'hA, 4'h9);
    chk_state("sat_load", 1, 1, 1, 4'h9, 4'd5);
    exp_stall = 4'd5;
    for (int c = 0; c < 20; c++) begin
      drive(0, 0, 0, 0, 16'h0000, 4'h0, 4'h0);
      if (exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
      tag = $sformatf("sat%0d", c);
      chk({tag, " stall_cnt"}, {28'd0, stall_cnt}, {28'd0, exp_stall});
      chk_data(tag, 16'h0A0A, 4'hA);
    end
    chk("sat_final", {28'd0, stall_cnt}, 32'd15);

    // mid-operation reset: fill skid with H, then reset while draining
    drive(0, 0, 1, 0, 16'h0B0B, 4'hB, 4'h2);
    chk_state("mr_fill", 1, 0, 2, 4'h9, 4'd15);
    drive(0, 0, 1, 1, 16'h0C0C, 4'hC, 4'h4);
    chk_state("mr_drain", 1, 1, 1, 4'h2, 4'd15);
    chk_data("mr_drain", 16'h0B0B, 4'hB);
    drive(0, 0, 1, 0, 16'h0C0C, 4'hC, 4'h4);
    chk_state("mr_refill", 1, 0, 2, 4'h2, 4'd15);
    drive(1, 0, 1, 1, 16'h0D0D, 4'hD, 4'h1);
    chk_state("mr_rst", 0, 1, 0, 4'h0, 4'd0);
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, c[0], 16'h0000, 4'h0, 4'h0);
      chk_state($sformatf("mr_idle%0d", c), 0, 1, 0, 4'h0, 4'd0);
    end
    drive(0, 0, 1, 1, 16'h0E0F, 4'h2, 4'h3);
    chk_state("mr_new", 1, 1, 1, 4'h3, 4'd0);
    chk_data("mr_new", 16'h0E0F, 4'h2);
    drive(0, 0, 0, 1, 16'h0000, 4'h0, 4'h0);
    chk_state("mr_empty", 0, 1, 0, 4'h0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Parametrised EX/MEM pipeline register with a valid/ready handshake, a 2-entry skid buffer, flush and a saturating stall counter.
- Carries the ALU result, store data, destination register and the packed control vector from EX to MEM.
- The MEM stage can back-pressure (e.g. multi-cycle memory) without a combinational ready path into EX.
- Full throughput (1 transfer/cycle) when unstalled.

Parameters:
- DATA_W, 16, width of ALU result and store data.
- RD_W, 4, width of destination register index.
- CTRL_W, 4, packed control vector width; bit0 reg_write, bit1 mem_read, bit2 mem_write, bit3 mem_to_reg.
- STALL_CNT_W, 16, width of stall statistics counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all held and incoming entries.
- in_valid  input  1  EX presents a valid instruction.
- in_ready  output  1  register can accept; registered signal.
- alu_result_in  input  DATA_W  ALU result / memory address.
- rs2_data_in  input  DATA_W  store data.
- rd_in  input  RD_W  destination register.
- ctrl_in  input  CTRL_W  control vector.
- out_valid  output  1  main entry holds a valid instruction.
- out_ready  input  1  MEM accepts this cycle.
- alu_result_out  output  DATA_W  main entry ALU result.
- rs2_data_out  output  DATA_W  main entry store data.
- rd_out  output  RD_W  main entry destination.
- ctrl_out  output  CTRL_W  main entry control, forced to 0 when out_valid=0 (bubble).
- occupancy  output  2  number of valid entries, 0..2.
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Storage: two entries, main (drives the outputs) and skid. Each entry holds payload plus a valid bit.
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready is registered, = ~skid_valid as computed for the next cycle. It never depends combinationally on out_ready.
- Update rules, evaluated in this priority order:
  1. rst: all valid bits 0, payload registers 0, in_ready=1, stall_cnt=0. Inputs are ignored that cycle.
  2. flush (not rst): main_valid=0 and skid_valid=0 next cycle, in_ready=1. Any in_fire that cycle is dropped. Payload registers may hold stale data, but ctrl_out must read 0. stall_cnt is unaffected.
  3. main empty: in_fire loads main; latency is 1 cycle from in_fire to out_valid.
  4. main full and out_fire:
     - if skid is valid: main <= skid, skid empties (in_ready was 0, so there is no in_fire);
     - otherwise: main <= input if in_fire, else main empties.
  5. main full, no out_fire, in_fire: skid <= input, in_ready drops to 0 next cycle.
  6. main full, no out_fire, no in_fire: hold.
- Ordering: strict FIFO; skid is never visible at the outputs before main.
- Output stability: payload outputs are stable while out_valid=1 and out_ready=0.
- occupancy = main_valid + skid_valid. The state main empty with skid valid is illegal and must never occur.
- stall_cnt: increments by 1 each cycle with out_valid & ~out_ready. It holds at all-ones, with no wrap. Cleared only by rst.
- Width rules: all payload fields are passed verbatim with no extension. ctrl_out = ctrl_main & {CTRL_W{out_valid}}.
- Reset mid-operation: in-flight entries are lost; rst takes priority over flush and over handshakes.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 and random data -> out_valid=0, ctrl_out=0, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1; send alu_result_in=0x1234, rd_in=3, ctrl_in=4'b0001 then 0x5678, rd_in=7, ctrl_in=4'b0011 on back-to-back cycles -> each appears exactly 1 cycle later, in order, in_ready stays 1, occupancy=1.
- Back-pressure: out_ready=0; send A=0x0001, B=0x0002, attempt C=0x0003 -> occupancy=2 and in_ready=0 after B, C is not accepted. Raise out_ready -> outputs A, B, C consecutively; stall_cnt equals the number of stalled cycles.
- Flush: with occupancy=2, assert flush together with in_valid=1, D=0xDEAD -> next cycle out_valid=0, ctrl_out=0, occupancy=0, in_ready=1, and D never appears.
- Saturation: STALL_CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Mid-operation reset: with occupancy=2 and out_ready toggling, pulse rst one cycle -> all state cleared next cycle and no stale entry emerges afterwards.
